// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, FSM state type and the write-back address rule
// for the radix-4 4x2-BFU coefficient RAM.
package ntt_pkg;

    localparam int ADDR_W = 10;
    localparam int LANES  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } wb_state_t;

    // Lane i of the group lives at index i
    typedef logic [LANES-1:0][ADDR_W-1:0] addr_vec_t;

    // In-place addresses of one read group.
    // p==0 is the contiguous first stage; p=1..4 builds two bases (a0, a0+1)
    // and ORs in the radix-4 stride masks for the remaining three lanes each.
    function automatic addr_vec_t wb_addr_calc(
        input logic [6:0] k,
        input logic [6:0] j,
        input logic [2:0] p
    );
        addr_vec_t         a;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] m1;
        logic [ADDR_W-1:0] m2;
        logic [ADDR_W-1:0] m3;
        logic [3:0]        sh;
        a    = '0;
        base = '0;
        sh   = {p, 1'b0};
        m1   = ADDR_W'(1) << sh;
        m2   = ADDR_W'(2) << sh;
        m3   = ADDR_W'(3) << sh;
        if (p == 3'd0) begin
            for (int i = 0; i < LANES; i++)
                a[i] = ADDR_W'({k, 3'b000}) + ADDR_W'(i);
        end else begin
            for (int h = 0; h < 2; h++) begin
                base       = (ADDR_W'(k) << (sh + 4'd2)) + ADDR_W'(j) + ADDR_W'(h);
                a[4*h + 0] = base;
                a[4*h + 1] = base | m1;
                a[4*h + 2] = base | m2;
                a[4*h + 3] = base | m3;
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/wb_delay_line.sv
// wb_delay_line: DEPTH-stage shift register carrying {valid, last, 8 addresses}.
// en=0 freezes every stage. Payload registers only load when a valid entry
// arrives, so the tail stage keeps the most recently written group.
module wb_delay_line
    import ntt_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      in_valid,
    input  logic      in_last,
    input  addr_vec_t in_addr,
    output logic      out_valid,
    output logic      out_last,
    output addr_vec_t out_addr
);

    logic [DEPTH-1:0] vld_pipe;
    logic [DEPTH-1:0] last_pipe;
    addr_vec_t        addr_pipe [DEPTH];

    // valid / last flags advance every enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (en) begin
            vld_pipe  <= {vld_pipe[DEPTH-2:0], in_valid};
            last_pipe <= {last_pipe[DEPTH-2:0], in_valid & in_last};
        end
    end

    // payload moves only with valid entries so bubbles never overwrite held data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++)
                addr_pipe[s] <= '0;
        end else if (en) begin
            if (in_valid)
                addr_pipe[0] <= in_addr;
            for (int s = 1; s < DEPTH; s++)
                if (vld_pipe[s-1])
                    addr_pipe[s] <= addr_pipe[s-1];
        end
    end

    assign out_valid = vld_pipe[DEPTH-1];
    assign out_last  = last_pipe[DEPTH-1];
    assign out_addr  = addr_pipe[DEPTH-1];

endmodule

// File: rtl/writeback_address_generator.sv
// writeback_address_generator: recomputes the 8 in-place addresses of each
// issued read group and replays them LATENCY cycles later as RAM write
// addresses. Tracks stage drain and flags protocol errors.
// Optional build macro WB_STALL_EN adds a 'stall' input that freezes the
// delay line, FSM and outputs (wr_en forced low, in_ready low).
// ADDR_W must match ntt_pkg::ADDR_W.
module writeback_address_generator #(
    parameter int LATENCY = 6,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
`ifdef WB_STALL_EN
    input  logic              stall,
`endif
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [6:0]        in_k,
    input  logic [6:0]        in_j,
    input  logic [2:0]        in_p,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] new_address_0,
    output logic [ADDR_W-1:0] new_address_1,
    output logic [ADDR_W-1:0] new_address_2,
    output logic [ADDR_W-1:0] new_address_3,
    output logic [ADDR_W-1:0] new_address_4,
    output logic [ADDR_W-1:0] new_address_5,
    output logic [ADDR_W-1:0] new_address_6,
    output logic [ADDR_W-1:0] new_address_7,
    output logic              busy,
    output logic              stage_done,
    output logic              err
);
    import ntt_pkg::*;

    logic      stall_i;
    wb_state_t state_q;
    wb_state_t state_d;
    logic      p_ok;
    logic      accept;
    logic      dl_valid;
    logic      dl_last;
    logic      drain_done;
    addr_vec_t calc_addr;
    addr_vec_t dl_addr;

`ifdef WB_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    assign p_ok       = (in_p <= 3'd4);
    assign in_ready   = (state_q != DRAIN) && !stall_i;
    assign accept     = in_valid && in_ready && p_ok;
    assign calc_addr  = wb_addr_calc(in_k, in_j, in_p);
    assign wr_en      = dl_valid && !stall_i;
    assign drain_done = (state_q == DRAIN) && wr_en && dl_last;
    assign busy       = (state_q != IDLE);

    assign new_address_0 = dl_addr[0];
    assign new_address_1 = dl_addr[1];
    assign new_address_2 = dl_addr[2];
    assign new_address_3 = dl_addr[3];
    assign new_address_4 = dl_addr[4];
    assign new_address_5 = dl_addr[5];
    assign new_address_6 = dl_addr[6];
    assign new_address_7 = dl_addr[7];

    wb_delay_line #(
        .DEPTH (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall_i),
        .in_valid  (accept),
        .in_last   (in_last),
        .in_addr   (calc_addr),
        .out_valid (dl_valid),
        .out_last  (dl_last),
        .out_addr  (dl_addr)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state: stage opens on first accept, drains after the last-flagged group
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = in_last ? DRAIN : RUN;
            RUN:     if (accept && in_last) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // stage_done follows the final write by one cycle; err is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            stage_done <= drain_done;
            if (in_valid && (!in_ready || !p_ok))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_address_generator.sv
// Self-checking bench for writeback_address_generator: directed scenarios
// followed by a randomized stream compared against a queue-based model.
module tb_writeback_address_generator;

    localparam int LAT = 6;
    localparam int AW  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             in_valid;
    logic             in_last;
    logic [6:0]       in_k;
    logic [6:0]       in_j;
    logic [2:0]       in_p;
    logic             in_ready;
    logic             wr_en;
    logic             busy;
    logic             stage_done;
    logic             err;
    logic [7:0][AW-1:0] na;

    int cyc;
    int checks;
    int errors;

    typedef struct {
        int due;
        bit last;
        int a[8];
    } ent_t;

    ent_t q[$];
    int   m_last[8];
    bit   m_busy;
    bit   m_drain;
    bit   m_err;
    bit   m_done;

    always #5 clk = ~clk;

    writeback_address_generator #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef WB_STALL_EN
        .stall         (stall),
`endif
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_k          (in_k),
        .in_j          (in_j),
        .in_p          (in_p),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .new_address_0 (na[0]),
        .new_address_1 (na[1]),
        .new_address_2 (na[2]),
        .new_address_3 (na[3]),
        .new_address_4 (na[4]),
        .new_address_5 (na[5]),
        .new_address_6 (na[6]),
        .new_address_7 (na[7]),
        .busy          (busy),
        .stage_done    (stage_done),
        .err           (err)
    );

    // Reference address rule in plain arithmetic
    function automatic void ref_addrs(input int k, input int j, input int p, output int a[8]);
        int s;
        int b;
        if (p == 0) begin
            for (int i = 0; i < 8; i++) a[i] = k * 8 + i;
        end else begin
            s = 1 << (2 * p);
            b = (k * 4 * s + j) % 1024;
            for (int h = 0; h < 2; h++) begin
                int base;
                base         = (b + h) % 1024;
                a[4*h]       = base;
                a[4*h + 1]   = base | s;
                a[4*h + 2]   = base | (2 * s);
                a[4*h + 3]   = base | (3 * s);
            end
        end
    endfunction

    // Update the model with this cycle's inputs, then move to the next cycle
    task automatic advance();
        bit acc;
        ent_t e;
        acc = in_valid && !m_drain && !stall && (in_p <= 4) && !rst;
        if (rst) begin
            q.delete();
            m_last  = '{default: 0};
            m_busy  = 0;
            m_drain = 0;
            m_err   = 0;
            m_done  = 0;
        end else begin
            if (in_valid && (m_drain || stall || in_p > 4)) m_err = 1;
            m_done = 0;
            if (stall) begin
                foreach (q[i]) if (q[i].due >= cyc) q[i].due++;
            end else if (q.size() > 0 && q[0].due == cyc) begin
                m_last = q[0].a;
                if (q[0].last) begin
                    m_drain = 0;
                    m_busy  = 0;
                    m_done  = 1;
                end
                void'(q.pop_front());
            end
            if (acc) begin
                e.due  = cyc + LAT;
                e.last = in_last;
                ref_addrs(int'(in_k), int'(in_j), int'(in_p), e.a);
                q.push_back(e);
                m_busy = 1;
                if (in_last) m_drain = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1;
        advance();
        advance();
        rst = 0;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (stage_done !== 1'b0) begin errors++; $display("FAIL reset_stage_done got %b want 0", stage_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (na[i] !== '0) begin errors++; $display("FAIL reset_addr lane=%0d got %0d want 0", i, na[i]); end
        end
    endtask

    task automatic test_p0();
        int t;
        in_valid = 1; in_last = 0; in_k = 3; in_j = 0; in_p = 0;
        t = cyc;
        advance();
        in_valid = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            checks++;
            if (wr_en !== (cyc == t + LAT)) begin
                errors++; $display("FAIL p0_wr_en cyc=%0d got %b want %b", cyc - t, wr_en, cyc == t + LAT);
            end
            if (cyc >= t + LAT)
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (na[i] !== AW'(24 + i)) begin
                        errors++; $display("FAIL p0_addr lane=%0d got %0d want %0d", i, na[i], 24 + i);
                    end
                end
            checks++; if (stage_done !== 1'b0) begin errors++; $display("FAIL p0_stage_done got %b want 0", stage_done); end
            advance();
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL p0_busy got %b want 1", busy); end
    endtask

    task automatic test_p1();
        int t;
        int ex[8] = '{17, 21, 25, 29, 18, 22, 26, 30};
        in_valid = 1; in_last = 0; in_k = 1; in_j = 1; in_p = 1;
        t = cyc;
        advance();
        in_valid = 0;
        for (int c = 0; c < LAT + 1; c++) begin
            checks++;
            if (wr_en !== (cyc == t + LAT)) begin
                errors++; $display("FAIL p1_wr_en cyc=%0d got %b want %b", cyc - t, wr_en, cyc == t + LAT);
            end
            if (cyc == t + LAT)
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (na[i] !== AW'(ex[i])) begin
                        errors++; $display("FAIL p1_addr lane=%0d got %0d want %0d", i, na[i], ex[i]);
                    end
                end
            advance();
        end
    endtask

    task automatic test_p4_last();
        int t;
        int ex[8] = '{2, 258, 514, 770, 3, 259, 515, 771};
        in_valid = 1; in_last = 1; in_k = 0; in_j = 2; in_p = 4;
        t = cyc;
        advance();
        in_valid = 0; in_last = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            if (cyc == t + 1) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL p4_drain_ready got %b want 0", in_ready); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL p4_drain_busy got %b want 1", busy); end
            end
            checks++;
            if (wr_en !== (cyc == t + LAT)) begin
                errors++; $display("FAIL p4_wr_en cyc=%0d got %b want %b", cyc - t, wr_en, cyc == t + LAT);
            end
            if (cyc >= t + LAT)
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (na[i] !== AW'(ex[i])) begin
                        errors++; $display("FAIL p4_addr lane=%0d got %0d want %0d", i, na[i], ex[i]);
                    end
                end
            checks++;
            if (stage_done !== (cyc == t + LAT + 1)) begin
                errors++; $display("FAIL p4_stage_done cyc=%0d got %b want %b", cyc - t, stage_done, cyc == t + LAT + 1);
            end
            if (cyc >= t + LAT + 1) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL p4_idle_busy got %b want 0", busy); end
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL p4_idle_ready got %b want 1", in_ready); end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int a[8];
        int ex[5][8];
        t0 = cyc;
        for (int g = 0; g < 5; g++) begin
            in_valid = 1; in_last = (g == 4);
            in_k = 7'($urandom); in_j = 7'($urandom); in_p = 3'($urandom_range(0, 4));
            ref_addrs(int'(in_k), int'(in_j), int'(in_p), a);
            ex[g] = a;
            advance();
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b want 0", in_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err_pre got %b want 0", err); end
        in_valid = 1; in_last = 0; in_k = 9; in_j = 0; in_p = 0;
        advance();
        in_valid = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            if (cyc >= t0 + LAT && cyc < t0 + LAT + 5) begin
                checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL b2b_wr_en cyc=%0d got %b want 1", cyc - t0, wr_en); end
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (na[i] !== AW'(ex[cyc - t0 - LAT][i])) begin
                        errors++; $display("FAIL b2b_addr grp=%0d lane=%0d got %0d want %0d", cyc - t0 - LAT, i, na[i], ex[cyc - t0 - LAT][i]);
                    end
                end
            end else begin
                checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL b2b_extra_wr cyc=%0d got %b want 0", cyc - t0, wr_en); end
            end
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL b2b_err_sticky cyc=%0d got %b want 1", cyc - t0, err); end
            advance();
        end
    endtask

    task automatic test_bad_p_and_reset();
        rst = 1;
        advance();
        rst = 0;
        in_valid = 1; in_last = 0; in_k = 2; in_j = 0; in_p = 5;
        advance();
        in_valid = 0; in_p = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL badp_wr_en got %b want 0", wr_en); end
            advance();
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badp_err got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badp_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL badp_ready got %b want 1", in_ready); end
        for (int g = 0; g < 3; g++) begin
            in_valid = 1; in_last = 0; in_p = 0; in_k = 7'(g + 1);
            advance();
        end
        in_valid = 0;
        rst = 1;
        advance();
        rst = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en got %b want 0", wr_en); end
            checks++; if (na[0] !== '0) begin errors++; $display("FAIL rst_mid_addr got %0d want 0", na[0]); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err got %b want 0", err); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
            advance();
        end
    endtask

`ifdef WB_STALL_EN
    task automatic test_stall();
        int t;
        rst = 1;
        advance();
        rst = 0;
        in_valid = 1; in_last = 0; in_k = 5; in_j = 0; in_p = 0;
        t = cyc;
        advance();
        in_valid = 0;
        advance();
        for (int c = 0; c < LAT + 6; c++) begin
            stall = (cyc >= t + 2 && cyc <= t + 4);
            #1;
            if (stall) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", in_ready); end
            end
            checks++;
            if (wr_en !== (cyc == t + LAT + 3)) begin
                errors++; $display("FAIL stall_wr_en cyc=%0d got %b want %b", cyc - t, wr_en, cyc == t + LAT + 3);
            end
            if (cyc == t + LAT + 3)
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (na[i] !== AW'(40 + i)) begin
                        errors++; $display("FAIL stall_addr lane=%0d got %0d want %0d", i, na[i], 40 + i);
                    end
                end
            advance();
        end
        stall = 0;
    endtask
`endif

    task automatic test_random();
        bit e_wr;
        bit front_due;
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 79) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_last  = ($urandom_range(0, 11) == 0);
            in_k     = 7'($urandom);
            in_j     = 7'($urandom);
            in_p     = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
`ifdef WB_STALL_EN
            stall    = ($urandom_range(0, 7) == 0);
`endif
            #1;
            front_due = (q.size() > 0) && (q[0].due <= cyc);
            e_wr      = (q.size() > 0) && (q[0].due == cyc) && !stall;
            checks++;
            if (wr_en !== e_wr) begin errors++; $display("FAIL rnd_wr_en cyc=%0d got %b want %b", cyc, wr_en, e_wr); end
            for (int i = 0; i < 8; i++) begin
                if (e_wr) begin
                    checks++;
                    if (na[i] !== AW'(q[0].a[i])) begin
                        errors++; $display("FAIL rnd_addr cyc=%0d lane=%0d got %0d want %0d", cyc, i, na[i], q[0].a[i]);
                    end
                end else if (!front_due) begin
                    checks++;
                    if (na[i] !== AW'(m_last[i])) begin
                        errors++; $display("FAIL rnd_hold cyc=%0d lane=%0d got %0d want %0d", cyc, i, na[i], m_last[i]);
                    end
                end
            end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got %b want %b", cyc, busy, m_busy); end
            checks++; if (in_ready !== (!m_drain && !stall)) begin errors++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, in_ready, !m_drain && !stall); end
            checks++; if (stage_done !== m_done) begin errors++; $display("FAIL rnd_stage_done cyc=%0d got %b want %b", cyc, stage_done, m_done); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err cyc=%0d got %b want %b", cyc, err, m_err); end
            advance();
        end
        rst = 0; in_valid = 0; stall = 0;
    endtask

    initial begin
        rst = 1; stall = 0; in_valid = 0; in_last = 0;
        in_k = 0; in_j = 0; in_p = 0;
        cyc = 0; checks = 0; errors = 0;
        m_last = '{default: 0};
        m_busy = 0; m_drain = 0; m_err = 0; m_done = 0;
        test_reset();
        test_p0();
        test_p1();
        test_p4_last();
        test_back_to_back();
        test_bad_p_and_reset();
`ifdef WB_STALL_EN
        test_stall();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
